// File: rtl/prng_stream_checker.sv
// Consumer-side checker for the 4-bit PRNG link: predicts each beat
// from the shared seed and tracks lock, loss of sync and error count.
module prng_stream_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [11:0]      seed_in,
  input  logic [3:0]       prev_init,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             match,
  output logic             mismatch,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_MAX =
    (LOCK_COUNT > ERR_LIMIT) ? LOCK_COUNT : ERR_LIMIT;
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_C = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] ERR_C  = RUN_W'(ERR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_LOCKED,
    S_LOST
  } state_e;

  state_e           state_q, state_d;
  logic [11:0]      seed_q, seed_d;
  logic [3:0]       prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             match_q, match_d;
  logic             mismatch_q, mismatch_d;

  logic [3:0]       exp_val;
  logic [1:0]       mul_unused;
  logic [RUN_W-1:0] run_inc;
  logic [CNT_W-1:0] err_inc;
  logic             accept;
  logic             hit;

  // Mode 11 recurrence: 3*prev+4 needs six bits before the mod-16 wrap.
  always_comb begin
    {mul_unused, exp_val} = 6'd3 * {2'b00, prev_q} + 6'd4;
    unique case (seed_q[1:0])
      2'b00: exp_val = seed_q[3:0];
      2'b01: exp_val = seed_q[7:4];
      2'b10: exp_val = seed_q[11:8];
      default: ;
    endcase
  end

  assign in_ready = ((state_q == S_SYNC) || (state_q == S_LOCKED))
                    && !seed_load;
  assign accept   = in_valid && in_ready;
  assign hit      = (in_data == exp_val);
  assign run_inc  = run_q + 1'b1;
  assign err_inc  = (&err_q) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    prev_d     = prev_q;
    run_d      = run_q;
    err_d      = err_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    if (seed_load) begin
      state_d = S_SYNC;
      seed_d  = seed_in;
      prev_d  = prev_init;
      run_d   = '0;
      err_d   = '0;
    end else if (accept) begin
      // Track the prediction, not the wire, so one bad beat cannot derail it.
      prev_d     = exp_val;
      match_d    = hit;
      mismatch_d = !hit;
      unique case (state_q)
        S_SYNC: begin
          if (hit) begin
            if (run_inc == LOCK_C) begin
              state_d = S_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
            err_d = err_inc;
          end
        end
        S_LOCKED: begin
          if (hit) begin
            run_d = '0;
          end else begin
            err_d = err_inc;
            run_d = run_inc;
            if (run_inc == ERR_C) state_d = S_LOST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seed_q     <= '0;
      prev_q     <= '0;
      run_q      <= '0;
      err_q      <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      err_q      <= err_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign locked    = (state_q == S_LOCKED);
  assign lost      = (state_q == S_LOST);
  assign err_count = err_q;

endmodule

// File: tb/tb_prng_stream_checker.sv
// Bench for prng_stream_checker: directed table, reset corner case
// and randomized traffic against a spec-level reference model.
module tb_prng_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [11:0] seed_in;
  logic [3:0]  prev_init;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready, match, mismatch, locked, lost;
  logic [7:0]  err_count;
  logic        in_ready2, match2, mismatch2, locked2, lost2;
  logic [1:0]  err_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prng_stream_checker dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load),
    .seed_in(seed_in), .prev_init(prev_init),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .match(match), .mismatch(mismatch),
    .locked(locked), .lost(lost), .err_count(err_count)
  );

  prng_stream_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load),
    .seed_in(seed_in), .prev_init(prev_init),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .match(match2), .mismatch(mismatch2),
    .locked(locked2), .lost(lost2), .err_count(err_count2)
  );

  // Reference model state
  localparam int M_IDLE = 0, M_SYNC = 1, M_LOCK = 2, M_LOST = 3;
  int          m_st;
  logic [11:0] m_seed;
  int          m_prev;
  int          m_run;
  int          m_err;
  bit          m_match, m_mis;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int m_exp();
    int sel;
    sel = int'(m_seed[1:0]);
    if (sel == 0) return int'(m_seed[3:0]);
    if (sel == 1) return int'(m_seed[7:4]);
    if (sel == 2) return int'(m_seed[11:8]);
    return (3 * m_prev + 4) % 16;
  endfunction

  function automatic bit m_ready(input bit sl);
    return (m_st == M_SYNC || m_st == M_LOCK) && !sl;
  endfunction

  task automatic m_reset();
    m_st = M_IDLE; m_seed = '0; m_prev = 0;
    m_run = 0; m_err = 0; m_match = 0; m_mis = 0;
  endtask

  task automatic m_step(input bit sl, input logic [11:0] s,
                        input logic [3:0] p, input bit v,
                        input logic [3:0] d);
    int e;
    bit ok;
    bit rdy;
    rdy = m_ready(sl);
    m_match = 0;
    m_mis = 0;
    if (sl) begin
      m_seed = s; m_prev = int'(p); m_err = 0; m_run = 0;
      m_st = M_SYNC;
    end else if (rdy && v) begin
      e = m_exp();
      ok = (int'(d) == e);
      m_prev = e;
      m_match = ok;
      m_mis = !ok;
      if (m_st == M_SYNC) begin
        if (ok) begin
          m_run++;
          if (m_run == 4) begin m_st = M_LOCK; m_run = 0; end
        end else begin
          m_run = 0; m_err++;
        end
      end else begin
        if (ok) m_run = 0;
        else begin
          m_err++; m_run++;
          if (m_run == 3) m_st = M_LOST;
        end
      end
    end
  endtask

  task automatic model_check();
    chk("match", match, m_match);
    chk("mismatch", mismatch, m_mis);
    chk("locked", locked, m_st == M_LOCK);
    chk("lost", lost, m_st == M_LOST);
    chk("err_count", err_count, m_err > 255 ? 255 : m_err);
    chk("err_count_w2", err_count2, m_err > 3 ? 3 : m_err);
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle(input bit sl, input logic [11:0] s,
                       input logic [3:0] p, input bit v,
                       input logic [3:0] d);
    seed_load = sl; seed_in = s; prev_init = p;
    in_valid = v; in_data = d;
    #1;
    chk("in_ready", in_ready, m_ready(sl));
    @(posedge clk);
    #1;
    m_step(sl, s, p, v, d);
  endtask

  typedef struct {
    bit          sl;
    logic [11:0] seed;
    logic [3:0]  pinit;
    bit          v;
    logic [3:0]  d;
    bit          m, mm, lk, ls;
    int          err, err2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit sl, logic [11:0] s, logic [3:0] p,
                              bit v, logic [3:0] d, bit m, bit mm,
                              bit lk, bit ls, int err, int err2);
    vec_t t;
    t.sl = sl; t.seed = s; t.pinit = p; t.v = v; t.d = d;
    t.m = m; t.mm = mm; t.lk = lk; t.ls = ls;
    t.err = err; t.err2 = err2;
    return t;
  endfunction

  initial begin
    bit sl;
    bit v;
    logic [11:0] s;
    logic [3:0] p, d;

    // Directed sequences
    tbl.push_back(mk(1, 12'hA5C, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hC, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hC, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hC, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hC, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 12'h003, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h9, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h7, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 12'h003, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4'hF, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4'h1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4'h7, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4'h9, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 12'h4B1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hB, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h3, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4'h3, 0, 1, 1, 0, 2, 2));
    tbl.push_back(mk(0, 0, 0, 1, 4'h3, 0, 1, 0, 1, 3, 3));
    tbl.push_back(mk(0, 0, 0, 1, 4'h3, 0, 0, 0, 1, 3, 3));
    tbl.push_back(mk(0, 0, 0, 1, 4'h3, 0, 0, 0, 1, 3, 3));
    tbl.push_back(mk(1, 12'h4B1, 0, 1, 4'hB, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h5, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4'h5, 0, 1, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0, 0, 1, 4'h5, 0, 1, 0, 0, 3, 3));
    tbl.push_back(mk(0, 0, 0, 1, 4'h5, 0, 1, 0, 0, 4, 3));

    rst_n = 1'b0;
    seed_load = 0; seed_in = 0; prev_init = 0;
    in_valid = 0; in_data = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 0);
    model_check();

    // Async reset while LOCKED with two errors outstanding
    cycle(1, 12'hA5C, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 4'hC);
    repeat (2) cycle(0, 0, 0, 1, 4'h3);
    model_check();
    chk("pre_reset_locked", locked, 1);
    chk("pre_reset_err", err_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err", err_count, 0);
    chk("async_match", match, 0);
    chk("async_mismatch", mismatch, 0);
    chk("async_lost", lost, 0);
    chk("async_in_ready", in_ready, 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 4'hC);
    model_check();
    cycle(0, 0, 0, 1, 4'hC);
    model_check();

    // Table-driven directed vectors
    foreach (tbl[i]) begin
      cycle(tbl[i].sl, tbl[i].seed, tbl[i].pinit, tbl[i].v, tbl[i].d);
      chk($sformatf("t%0d_match", i), match, tbl[i].m);
      chk($sformatf("t%0d_mismatch", i), mismatch, tbl[i].mm);
      chk($sformatf("t%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("t%0d_lost", i), lost, tbl[i].ls);
      chk($sformatf("t%0d_err", i), err_count, tbl[i].err);
      chk($sformatf("t%0d_err_w2", i), err_count2, tbl[i].err2);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      sl = ($urandom_range(0, 59) == 0) ||
           ((m_st == M_LOST || m_st == M_IDLE) &&
            $urandom_range(0, 3) == 0);
      s = 12'($urandom);
      p = 4'($urandom);
      v = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) < 8) d = 4'(m_exp());
      else d = 4'($urandom_range(0, 15));
      cycle(sl, s, p, v, d);
      model_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
